// File: rtl/pipeline_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_hazard_ctrl_pkg
//  Purpose  : Shared types and constants for the pipeline hazard controller:
//             multi-cycle FSM state type, forward-select encodings and
//             counter-width helpers.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package pipeline_hazard_ctrl_pkg;

  // Multi-cycle execute unit FSM states.
  typedef enum logic [1:0] {
    MC_IDLE = 2'd0,
    MC_BUSY = 2'd1,
    MC_DONE = 2'd2
  } mcState_t;

  // Operand-select encodings driven on ForwardAE / ForwardBE.
  localparam logic [1:0] FWD_RF = 2'b00;  // register file value
  localparam logic [1:0] FWD_M  = 2'b10;  // ALU result in memory stage
  localparam logic [1:0] FWD_W  = 2'b01;  // result in writeback stage

  // Bits needed to hold any value 0..maxVal (never less than one bit).
  function automatic int cntWidth(input int maxVal);
    if (maxVal < 1) begin
      return 1;
    end
    return $clog2(maxVal + 1);
  endfunction

  // Down-counter load for a multi-cycle op. The entry cycle and the DONE
  // cycle are spent outside the BUSY window, hence the "- 2".
  function automatic int mcLoadValue(input int latency);
    if (latency > 1) begin
      return latency - 2;
    end
    return 0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_fwd_sel.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_fwd_sel
//  Purpose  : Operand forwarding select for one execute-stage source register.
//             The memory stage has priority over writeback because it holds
//             the younger result; register x0 is never forwarded.
//  Ports    : RsE        - execute-stage source register
//             RdM, RdW   - memory / writeback destination registers
//             RegWriteM  - memory-stage instruction writes the register file
//             RegWriteW  - writeback-stage instruction writes the register file
//             ForwardE   - operand select (FWD_RF / FWD_M / FWD_W)
//  Revision : 1.0 - initial release
// ============================================================================
module hazard_fwd_sel #(
  parameter int AW = 5
) (
  input  logic [AW-1:0] RsE,
  input  logic [AW-1:0] RdM,
  input  logic [AW-1:0] RdW,
  input  logic          RegWriteM,
  input  logic          RegWriteW,
  output logic [1:0]    ForwardE
);

  import pipeline_hazard_ctrl_pkg::*;

  logic w_hitM;
  logic w_hitW;

  assign w_hitM = RegWriteM && (RdM != '0) && (RdM == RsE);
  assign w_hitW = RegWriteW && (RdW != '0) && (RdW == RsE);

  always_comb begin
    ForwardE = FWD_RF;
    if (w_hitM) begin
      ForwardE = FWD_M;
    end else if (w_hitW) begin
      ForwardE = FWD_W;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_hazard_ctrl
//  Purpose  : Hazard unit for a 5-stage pipeline: operand forwarding,
//             load-use stall, branch flush, multi-cycle (mul/div) execute
//             occupancy FSM and a saturating stall-cycle counter.
//  Ports    : clk                 - clock, rising edge
//             reset               - asynchronous active-low reset
//             Rs1D, Rs2D          - decode-stage source registers
//             Rs1E, Rs2E, RdE     - execute-stage sources / destination
//             RdM, RdW            - memory / writeback destinations
//             RegWriteM/W         - stage writes the register file
//             ResultSrcE0         - load instruction in execute
//             PCSrcE              - taken branch/jump resolved in execute
//             McStartE            - multi-cycle op present in execute
//             ForwardAE/BE        - operand selects (00 RF, 10 M, 01 W)
//             StallF/D/E          - hold stage register
//             FlushD/E/M          - clear stage register to a bubble
//             McBusy              - multi-cycle unit occupied
//             StallCount          - saturating count of StallF cycles
//  Revision : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl #(
  parameter int AW         = 5,
  parameter int MC_LATENCY = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [AW-1:0]    Rs1D,
  input  logic [AW-1:0]    Rs2D,
  input  logic [AW-1:0]    Rs1E,
  input  logic [AW-1:0]    Rs2E,
  input  logic [AW-1:0]    RdE,
  input  logic [AW-1:0]    RdM,
  input  logic [AW-1:0]    RdW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             ResultSrcE0,
  input  logic             PCSrcE,
  input  logic             McStartE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushM,
  output logic             McBusy,
  output logic [CNT_W-1:0] StallCount
);

  import pipeline_hazard_ctrl_pkg::*;

  localparam int                  MC_CNT_W     = cntWidth(MC_LATENCY);
  localparam logic [MC_CNT_W-1:0] MC_LOAD      = MC_CNT_W'(mcLoadValue(MC_LATENCY));
  // A single-cycle op never engages the FSM.
  localparam logic                MC_USES_FSM  = (MC_LATENCY > 1);
  // A two-cycle op has no BUSY cycles to spend: entry goes straight to DONE
  // so that E is occupied for exactly two cycles.
  localparam logic                MC_SKIP_BUSY = (MC_LATENCY == 2);

  mcState_t            r_mcState;
  mcState_t            w_mcStateNext;
  logic [MC_CNT_W-1:0] r_mcCnt;
  logic [MC_CNT_W-1:0] w_mcCntNext;
  logic                w_mcStall;
  logic                w_lwStall;
  logic [1:0]          w_fwdA;
  logic [1:0]          w_fwdB;
  logic [CNT_W-1:0]    r_stallCount;

  // --------------------------------------------------------------------------
  // Forwarding: one selector per execute-stage operand.
  // --------------------------------------------------------------------------
  hazard_fwd_sel #(.AW(AW)) u_fwdA (
    .RsE       (Rs1E),
    .RdM       (RdM),
    .RdW       (RdW),
    .RegWriteM (RegWriteM),
    .RegWriteW (RegWriteW),
    .ForwardE  (w_fwdA)
  );

  hazard_fwd_sel #(.AW(AW)) u_fwdB (
    .RsE       (Rs2E),
    .RdM       (RdM),
    .RdW       (RdW),
    .RegWriteM (RegWriteM),
    .RegWriteW (RegWriteW),
    .ForwardE  (w_fwdB)
  );

  // --------------------------------------------------------------------------
  // Load-use hazard: the load in E produces its value too late for the
  // instruction in D.
  // --------------------------------------------------------------------------
  assign w_lwStall = ResultSrcE0 && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));

  // --------------------------------------------------------------------------
  // Multi-cycle FSM: state register.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mcState <= MC_IDLE;
      r_mcCnt   <= '0;
    end else begin
      r_mcState <= w_mcStateNext;
      r_mcCnt   <= w_mcCntNext;
    end
  end

  // --------------------------------------------------------------------------
  // Multi-cycle FSM: next-state logic.
  // BUSY leaves when the down-counter reaches zero this cycle, so the stall
  // window is entry cycle + (MC_LATENCY-2) BUSY cycles, and DONE is the final
  // cycle of the op in E.
  // --------------------------------------------------------------------------
  always_comb begin
    w_mcStateNext = r_mcState;
    w_mcCntNext   = r_mcCnt;
    case (r_mcState)
      MC_IDLE: begin
        if (McStartE && MC_USES_FSM) begin
          w_mcCntNext = MC_LOAD;
          if (MC_SKIP_BUSY) begin
            w_mcStateNext = MC_DONE;
          end else begin
            w_mcStateNext = MC_BUSY;
          end
        end
      end
      MC_BUSY: begin
        if (r_mcCnt != '0) begin
          w_mcCntNext = r_mcCnt - 1'b1;
        end
        if (r_mcCnt <= MC_CNT_W'(1)) begin
          w_mcStateNext = MC_DONE;
        end
      end
      MC_DONE: begin
        // McStartE still shows the finishing op here; it must not restart.
        w_mcStateNext = MC_IDLE;
      end
      default: begin
        w_mcStateNext = MC_IDLE;
        w_mcCntNext   = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Multi-cycle FSM: outputs. The entry cycle stalls combinationally so the
  // op is held in E from its very first cycle.
  // --------------------------------------------------------------------------
  always_comb begin
    w_mcStall = 1'b0;
    case (r_mcState)
      MC_IDLE: w_mcStall = McStartE && MC_USES_FSM;
      MC_BUSY: w_mcStall = 1'b1;
      default: w_mcStall = 1'b0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Pipeline control outputs, all forced inactive while reset is held.
  // While the multi-cycle op is held in E a load-use stall must not bubble E.
  // --------------------------------------------------------------------------
  assign StallF    = reset && (w_lwStall || w_mcStall);
  assign StallD    = reset && (w_lwStall || w_mcStall);
  assign StallE    = reset && w_mcStall;
  assign FlushD    = reset && PCSrcE;
  assign FlushE    = reset && ((w_lwStall && !w_mcStall) || PCSrcE);
  assign FlushM    = reset && w_mcStall;
  assign McBusy    = reset && w_mcStall;
  assign ForwardAE = reset ? w_fwdA : FWD_RF;
  assign ForwardBE = reset ? w_fwdB : FWD_RF;

  // --------------------------------------------------------------------------
  // Stall-cycle counter, saturating at all-ones.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stallCount <= '0;
    end else if (StallF && (r_stallCount != '1)) begin
      r_stallCount <= r_stallCount + 1'b1;
    end
  end

  assign StallCount = r_stallCount;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipeline_hazard_ctrl
//  Purpose  : Self-checking bench for pipeline_hazard_ctrl (MC_LATENCY=4,
//             CNT_W=4): table of combinational hazard vectors followed by
//             hand-written multi-cycle, reset-abort and saturation sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

  localparam int AW    = 5;
  localparam int CNT_W = 4;

  logic             clk;
  logic             reset;
  logic [AW-1:0]    Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic             RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, McStartE;
  logic [1:0]       ForwardAE, ForwardBE;
  logic             StallF, StallD, StallE, FlushD, FlushE, FlushM, McBusy;
  logic [CNT_W-1:0] StallCount;

  int testsRun    = 0;
  int testsFailed = 0;

  pipeline_hazard_ctrl #(.AW(AW), .MC_LATENCY(4), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .Rs1D        (Rs1D),
    .Rs2D        (Rs2D),
    .Rs1E        (Rs1E),
    .Rs2E        (Rs2E),
    .RdE         (RdE),
    .RdM         (RdM),
    .RdW         (RdW),
    .RegWriteM   (RegWriteM),
    .RegWriteW   (RegWriteW),
    .ResultSrcE0 (ResultSrcE0),
    .PCSrcE      (PCSrcE),
    .McStartE    (McStartE),
    .ForwardAE   (ForwardAE),
    .ForwardBE   (ForwardBE),
    .StallF      (StallF),
    .StallD      (StallD),
    .StallE      (StallE),
    .FlushD      (FlushD),
    .FlushE      (FlushE),
    .FlushM      (FlushM),
    .McBusy      (McBusy),
    .StallCount  (StallCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {ForwardAE, ForwardBE, StallF, StallD, StallE, FlushD, FlushE, FlushM, McBusy}
  logic [10:0] actOut;
  assign actOut = {ForwardAE, ForwardBE, StallF, StallD, StallE, FlushD, FlushE, FlushM, McBusy};

  // {StallF, StallD, StallE, FlushM, McBusy}
  logic [4:0] mcOut;
  assign mcOut = {StallF, StallD, StallE, FlushM, McBusy};

  typedef struct {
    string       name;
    logic [4:0]  rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic        regWriteM, regWriteW, resultSrcE0, pcSrcE;
    logic [10:0] expOut;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clearInputs();
    Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0; RdE = '0; RdM = '0; RdW = '0;
    RegWriteM = 1'b0; RegWriteW = 1'b0; ResultSrcE0 = 1'b0; PCSrcE = 1'b0; McStartE = 1'b0;
  endtask

  // Short asynchronous reset pulse placed mid-cycle.
  task automatic doReset();
    @(posedge clk);
    #1;
    clearInputs();
    reset = 1'b0;
    #2;
    reset = 1'b1;
  endtask

  task automatic setLoadUse();
    ResultSrcE0 = 1'b1; RdE = 5'd5; Rs1D = 5'd5;
  endtask

  initial begin
    //               name          rs1D rs2D rs1E rs2E rdE  rdM  rdW  rwM rwW ld  pc   fA    fB    F D E fD fE fM busy
    vecs[0]  = '{"idle",          0,   0,   0,   0,   0,   0,   0,   0,  0,  0,  0,  {2'b00,2'b00,7'b0000000}};
    vecs[1]  = '{"fwdA_Mprio",    0,   0,   3,   0,   0,   3,   3,   1,  1,  0,  0,  {2'b10,2'b00,7'b0000000}};
    vecs[2]  = '{"fwdA_RdM0",     0,   0,   3,   0,   0,   0,   3,   1,  1,  0,  0,  {2'b01,2'b00,7'b0000000}};
    vecs[3]  = '{"fwd_noRegWrM",  0,   0,   3,   3,   0,   3,   3,   0,  1,  0,  0,  {2'b01,2'b01,7'b0000000}};
    vecs[4]  = '{"fwdB_M",        0,   0,   2,   7,   0,   7,   7,   1,  1,  0,  0,  {2'b00,2'b10,7'b0000000}};
    vecs[5]  = '{"fwd_x0_never",  0,   0,   0,   0,   0,   0,   0,   1,  1,  0,  0,  {2'b00,2'b00,7'b0000000}};
    vecs[6]  = '{"lw_rs2",        0,   5,   0,   0,   5,   0,   0,   0,  0,  1,  0,  {2'b00,2'b00,7'b1100100}};
    vecs[7]  = '{"lw_rd0",        0,   0,   0,   0,   0,   0,   0,   0,  0,  1,  0,  {2'b00,2'b00,7'b0000000}};
    vecs[8]  = '{"lw_rs1",        5,   0,   0,   0,   5,   0,   0,   0,  0,  1,  0,  {2'b00,2'b00,7'b1100100}};
    vecs[9]  = '{"noLoad",        5,   0,   0,   0,   5,   0,   0,   0,  0,  0,  0,  {2'b00,2'b00,7'b0000000}};
    vecs[10] = '{"branch",        0,   0,   0,   0,   0,   0,   0,   0,  0,  0,  1,  {2'b00,2'b00,7'b0001100}};
    vecs[11] = '{"branch_lw",     9,   0,   0,   0,   9,   0,   0,   0,  0,  1,  1,  {2'b00,2'b00,7'b1101100}};
    vecs[12] = '{"fwdA_M_fwdB_W", 0,   0,   4,   6,   0,   4,   6,   1,  1,  0,  0,  {2'b10,2'b01,7'b0000000}};

    clearInputs();
    reset = 1'b0;

    // ---- Reset state: outputs forced inactive even with hazards on inputs.
    repeat (2) @(posedge clk);
    #1;
    setLoadUse();
    PCSrcE = 1'b1; McStartE = 1'b1;
    RdM = 5'd3; RegWriteM = 1'b1; Rs1E = 5'd3;
    #1;
    check("reset_outputs", {21'd0, actOut}, 32'd0);
    check("reset_count", {28'd0, StallCount}, 32'd0);
    @(posedge clk);
    #1;
    clearInputs();
    reset = 1'b1;
    @(negedge clk);
    check("post_reset_outputs", {21'd0, actOut}, 32'd0);
    check("post_reset_count", {28'd0, StallCount}, 32'd0);

    // ---- Table-driven combinational vectors (FSM idle).
    for (int i = 0; i < 13; i++) begin
      @(posedge clk);
      #1;
      clearInputs();
      Rs1D = vecs[i].rs1D; Rs2D = vecs[i].rs2D; Rs1E = vecs[i].rs1E; Rs2E = vecs[i].rs2E;
      RdE = vecs[i].rdE; RdM = vecs[i].rdM; RdW = vecs[i].rdW;
      RegWriteM = vecs[i].regWriteM; RegWriteW = vecs[i].regWriteW;
      ResultSrcE0 = vecs[i].resultSrcE0; PCSrcE = vecs[i].pcSrcE;
      @(negedge clk);
      check(vecs[i].name, {21'd0, actOut}, {21'd0, vecs[i].expOut});
    end

    // ---- Multi-cycle op, latency 4, McStartE held for the whole occupancy.
    doReset();
    @(posedge clk);
    #1;
    McStartE = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      if (k == 1) setLoadUse();
      if (k == 2) begin
        ResultSrcE0 = 1'b0; RdE = '0; Rs1D = '0;
        RdM = 5'd3; RegWriteM = 1'b1; Rs1E = 5'd3;
      end
      @(negedge clk);
      check($sformatf("mc_stall_c%0d", k), {27'd0, mcOut}, 32'h1F);
      if (k == 1) check("mc_lw_noFlushE", {31'd0, FlushE}, 32'd0);
      if (k == 2) check("mc_fwd_valid", {30'd0, ForwardAE}, 32'd2);
    end
    @(posedge clk);
    #1;
    RdM = '0; RegWriteM = 1'b0; Rs1E = '0;
    @(negedge clk);
    check("mc_done_release", {27'd0, mcOut}, 32'd0);
    check("mc_stallcount", {28'd0, StallCount}, 32'd3);
    @(posedge clk);
    #1;
    McStartE = 1'b0;
    @(negedge clk);
    check("mc_back_idle", {27'd0, mcOut}, 32'd0);
    check("mc_count_hold", {28'd0, StallCount}, 32'd3);

    // ---- Reset asserted in the middle of BUSY aborts the op.
    @(posedge clk);
    #1;
    McStartE = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_busy_before", {31'd0, McBusy}, 32'd1);
    #1;
    reset = 1'b0;
    #1;
    check("abort_outputs", {27'd0, mcOut}, 32'd0);
    check("abort_count", {28'd0, StallCount}, 32'd0);
    McStartE = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("abort_idle_after", {27'd0, mcOut}, 32'd0);
    @(posedge clk);
    #1;
    McStartE = 1'b1;
    @(negedge clk);
    check("abort_restart", {27'd0, mcOut}, 32'h1F);
    @(posedge clk);
    #1;
    McStartE = 1'b0;

    // ---- Saturation: continuous load-use stall for 20 cycles.
    doReset();
    @(posedge clk);
    #1;
    setLoadUse();
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("sat_count10", {28'd0, StallCount}, 32'd10);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("sat_count20", {28'd0, StallCount}, 32'd15);
    clearInputs();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter: AW, 5, register-address width.
REQ-002 SHALL have parameter: MC_LATENCY, 4, execute cycles of a multi-cycle op (mul/div), legal range 1..16.
REQ-003 SHALL have parameter: CNT_W, 16, width of stall-cycle counter.
REQ-004 SHALL have port: clk  input  1  single clock, rising edge.
REQ-005 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have ports: Rs1D, Rs2D  input  AW  decode-stage source registers.
REQ-007 SHALL have ports: Rs1E, Rs2E, RdE  input  AW  execute-stage sources/destination.
REQ-008 SHALL have ports: RdM, RdW  input  AW  memory/writeback destinations.
REQ-009 SHALL have ports: RegWriteM, RegWriteW  input  1  stage writes register file.
REQ-010 SHALL have port: ResultSrcE0  input  1  load instruction in E.
REQ-011 SHALL have port: PCSrcE  input  1  taken branch/jump resolved in E.
REQ-012 SHALL have port: McStartE  input  1  multi-cycle op present in E.
REQ-013 SHALL have ports: ForwardAE, ForwardBE  output  2  operand select: 00 regfile, 10 from M, 01 from W.
REQ-014 SHALL have ports: StallF, StallD, StallE  output  1  hold stage register.
REQ-015 SHALL have ports: FlushD, FlushE, FlushM  output  1  clear stage register to bubble.
REQ-016 SHALL have port: McBusy  output  1  multi-cycle unit occupied.
REQ-017 SHALL have port: StallCount  output  CNT_W  saturating count of cycles with StallF=1.

Function
REQ-018 ForwardAE SHALL be 10 when RegWriteM & RdM!=0 & RdM==Rs1E; else 01 when RegWriteW & RdW!=0 & RdW==Rs1E; else 00 (M priority over W); ForwardBE identically with Rs2E.
REQ-019 Load-use stall lwStall SHALL be ResultSrcE0 & RdE!=0 & (RdE==Rs1D | RdE==Rs2D), combinational.
REQ-020 lwStall SHALL assert StallF, StallD, FlushE in the same cycle.
REQ-021 PCSrcE SHALL assert FlushD and FlushE; with simultaneous lwStall, FlushE=1 and StallF/StallD remain asserted.
REQ-022 Multi-cycle FSM states SHALL be MC_IDLE, MC_BUSY, MC_DONE.
REQ-023 MC_IDLE -> MC_BUSY on McStartE when MC_LATENCY>1, loading down-counter with MC_LATENCY-2; when MC_LATENCY==1 FSM SHALL stay MC_IDLE, no stall.
REQ-024 In MC_BUSY and in the MC_IDLE cycle where McStartE triggers entry: StallF=StallD=StallE=1, FlushM=1, McBusy=1; counter decrements per cycle.
REQ-025 MC_BUSY -> MC_DONE when counter==0; MC_DONE releases all MC stalls and FlushM, McBusy=0, McStartE ignored; MC_DONE -> MC_IDLE unconditionally.
REQ-026 Total op occupancy in E SHALL be exactly MC_LATENCY cycles.
REQ-027 While McBusy, lwStall SHALL NOT assert FlushE (E holds the multi-cycle op); PCSrcE cannot occur (E is not a branch).
REQ-028 Forwarding SHALL remain combinationally valid in every FSM state.
REQ-029 StallCount SHALL increment each cycle StallF=1, saturating at all-ones (no wrap).

Reset
REQ-030 reset low SHALL immediately force FSM MC_IDLE, down-counter 0, StallCount 0.
REQ-031 While reset low all stall/flush outputs and McBusy SHALL be 0; forwarding outputs 00.
REQ-032 Reset asserted mid-MC_BUSY SHALL abort the op; first cycle after release is MC_IDLE.

Structure
REQ-033 Shared package SHALL hold FSM state typedef, forward-select encodings (FWD_RF, FWD_M, FWD_W) and counter-width helpers.
REQ-034 Forward-select logic SHALL be one sub-module, hazard_fwd_sel, instantiated once per operand.

Verification
REQ-035 RdM=3,RegWriteM=1,RdW=3,RegWriteW=1,Rs1E=3 -> ForwardAE=10; RdM=0 same case -> ForwardAE=01.
REQ-036 ResultSrcE0=1,RdE=5,Rs2D=5 -> StallF=StallD=FlushE=1 one cycle; RdE=0 -> no stall.
REQ-037 MC_LATENCY=4, McStartE pulse-held -> StallE=1 cycles 0..2, MC_DONE cycle 3, StallCount=3.
REQ-038 PCSrcE=1 with lwStall -> FlushD=FlushE=StallF=1.
REQ-039 reset low during MC_BUSY -> McBusy=0 immediately, StallCount=0, MC_IDLE after release.
REQ-040 CNT_W=4, continuous stall 20 cycles -> StallCount holds 15.
